// File: rtl/shared_adder33_sched.sv
// Round-robin scheduler sharing one 33+11-bit unsigned adder between NUM_REQ requesters.
// Optional overflow flag and saturating overflow counter: define SHARED_ADDER33_SCHED_OVF_EN.
module shared_adder33_sched #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*33-1:0] req_a,
    input  logic [NUM_REQ*11-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [33:0]           rsp_sum,
    output logic [ID_W-1:0]       rsp_id
`ifdef SHARED_ADDER33_SCHED_OVF_EN
    ,
    output logic                  rsp_ovf,
    output logic [15:0]           ovf_cnt
`endif
);

    localparam int unsigned A_W = 33;
    localparam int unsigned B_W = 11;
    localparam int unsigned S_W = 34;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id;
    logic [A_W-1:0]  op_a;
    logic [B_W-1:0]  op_b;

    logic            grant_vld;
    logic [ID_W-1:0] grant_id;
    logic [A_W-1:0]  gnt_a;
    logic [B_W-1:0]  gnt_b;
    logic [S_W-1:0]  sum_c;
    int unsigned     idx;

    // Rotating priority search starting at rr_ptr; first valid requester wins.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!grant_vld && req_valid[ID_W'(idx)]) begin
                grant_vld = 1'b1;
                grant_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        gnt_a = '0;
        gnt_b = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (grant_id == ID_W'(i)) begin
                gnt_a = req_a[A_W*i +: A_W];
                gnt_b = req_b[B_W*i +: B_W];
            end
        end
    end

    // Ready is only offered in IDLE, so a grant and its handshake coincide.
    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_vld && !rst) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign sum_c = {1'b0, op_a} + S_W'(op_b);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_sum   <= '0;
            rsp_id    <= '0;
`ifdef SHARED_ADDER33_SCHED_OVF_EN
            rsp_ovf   <= 1'b0;
            ovf_cnt   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        op_a  <= gnt_a;
                        op_b  <= gnt_b;
                        id    <= grant_id;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_sum   <= sum_c;
                    rsp_id    <= id;
                    rsp_valid <= 1'b1;
`ifdef SHARED_ADDER33_SCHED_OVF_EN
                    rsp_ovf   <= sum_c[S_W-1];
`endif
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
`ifdef SHARED_ADDER33_SCHED_OVF_EN
                        if (rsp_ovf && ovf_cnt != 16'hFFFF) begin
                            ovf_cnt <= ovf_cnt + 16'd1;
                        end
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shared_adder33_sched.sv
// Bench for shared_adder33_sched: directed scenarios plus randomized traffic against a
// round-robin / arithmetic reference model.
module tb_shared_adder33_sched;

    localparam int unsigned N    = 4;
    localparam int unsigned ID_W = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [N*33-1:0]    req_a;
    logic [N*11-1:0]    req_b;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [33:0]        rsp_sum;
    logic [ID_W-1:0]    rsp_id;
`ifdef SHARED_ADDER33_SCHED_OVF_EN
    logic               rsp_ovf;
    logic [15:0]        ovf_cnt;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;
    int model_ptr = 0;
    int model_ovf = 0;

    always #5 clk = ~clk;

    shared_adder33_sched #(.NUM_REQ(N), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_id    (rsp_id)
`ifdef SHARED_ADDER33_SCHED_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf),
        .ovf_cnt   (ovf_cnt)
`endif
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference arbitration: first valid index at or after the pointer, with wrap.
    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < int'(N); k++) begin
            int j;
            j = (ptr + k) % int'(N);
            if (v[j[1:0]]) return j;
        end
        return -1;
    endfunction

    task automatic randomize_ops();
        for (int i = 0; i < int'(N); i++) begin
            logic [63:0] r;
            r = {$urandom(), $urandom()};
            if ($urandom_range(0, 3) == 0) r = '1;
            req_a[33*i +: 33] = r[32:0];
            req_b[11*i +: 11] = 11'($urandom());
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '1;
        rsp_ready = 1'b0;
        randomize_ops();
        repeat (2) @(posedge clk);
        #1;
        check("reset_req_ready", 64'(req_ready), 64'(0));
        req_valid = '0;
        rst       = 1'b0;
        model_ptr = 0;
        model_ovf = 0;
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_sum", 64'(rsp_sum), 64'(0));
        check("reset_rsp_id", 64'(rsp_id), 64'(0));
`ifdef SHARED_ADDER33_SCHED_OVF_EN
        check("reset_rsp_ovf", 64'(rsp_ovf), 64'(0));
        check("reset_ovf_cnt", 64'(ovf_cnt), 64'(0));
`endif
    endtask

    // One full transaction starting in IDLE, just after a rising edge.
    task automatic run_txn(input logic [N-1:0] vmask, input int stall,
                           input bit force_ops, input logic [32:0] fa, input logic [10:0] fb);
        int          g;
        logic [63:0] es;
        randomize_ops();
        if (force_ops) begin
            for (int i = 0; i < int'(N); i++) begin
                req_a[33*i +: 33] = fa;
                req_b[11*i +: 11] = fb;
            end
        end
        req_valid = vmask;
        rsp_ready = 1'b1;
        g  = pick(model_ptr, vmask);
        es = 64'(req_a[33*g +: 33]) + 64'(req_b[11*g +: 11]);
        #1;
        check("grant_ready", 64'(req_ready), 64'(1) << g);
        @(posedge clk);
        #1;
        randomize_ops();
        check("exec_ready", 64'(req_ready), 64'(0));
        check("exec_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1;
        check("rsp_valid", 64'(rsp_valid), 64'(1));
        check("rsp_sum", 64'(rsp_sum), es);
        check("rsp_id", 64'(rsp_id), 64'(g));
        check("resp_ready", 64'(req_ready), 64'(0));
`ifdef SHARED_ADDER33_SCHED_OVF_EN
        check("rsp_ovf", 64'(rsp_ovf), 64'(es[33]));
`endif
        rsp_ready = (stall == 0);
        for (int s = 0; s < stall; s++) begin
            @(posedge clk);
            #1;
            randomize_ops();
            check("stall_valid", 64'(rsp_valid), 64'(1));
            check("stall_sum", 64'(rsp_sum), es);
            check("stall_id", 64'(rsp_id), 64'(g));
            check("stall_ready", 64'(req_ready), 64'(0));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        model_ptr = (g + 1) % int'(N);
        if (es[33]) model_ovf++;
        check("post_valid", 64'(rsp_valid), 64'(0));
`ifdef SHARED_ADDER33_SCHED_OVF_EN
        check("ovf_cnt", 64'(ovf_cnt), 64'(model_ovf));
`endif
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        @(posedge clk);
        do_reset();

        // Single requester with small operands.
        run_txn(4'b0001, 0, 1'b1, 33'h0_0000_0010, 11'h005);
        // Carry boundary on requester 2.
        run_txn(4'b0100, 0, 1'b1, 33'h1_FFFF_FFFF, 11'h7FF);
        check("carry_sum_const", 64'(rsp_sum), 64'h2_0000_07FE);

        // Round robin from a fresh pointer with all requesters valid.
        do_reset();
        for (int i = 0; i < 5; i++) run_txn(4'b1111, 0, 1'b0, '0, '0);

        // Backpressure with other requests pending.
        run_txn(4'b1111, 5, 1'b0, '0, '0);

        // Idle cycle: no request, no grant, rsp_ready ignored outside RESP.
        req_valid = '0;
        rsp_ready = 1'b1;
        #1;
        check("idle_ready", 64'(req_ready), 64'(0));
        @(posedge clk);
        #1;
        check("idle_valid", 64'(rsp_valid), 64'(0));

        // Reset while requester 1 is in EXEC.
        req_valid = 4'b0010;
        #1;
        check("pre_rst_grant", 64'(req_ready), 64'(4'b0010));
        @(posedge clk);
        #1;
        req_valid = '0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        model_ptr = 0;
        model_ovf = 0;
        check("rst_exec_valid", 64'(rsp_valid), 64'(0));
        @(posedge clk);
        #1;
        check("rst_exec_valid2", 64'(rsp_valid), 64'(0));
`ifdef SHARED_ADDER33_SCHED_OVF_EN
        check("rst_exec_ovf_cnt", 64'(ovf_cnt), 64'(0));
`endif
        run_txn(4'b0011, 0, 1'b0, '0, '0);

        // Pointer wrap: after requester 3, requester 0 beats requester 3.
        run_txn(4'b1000, 0, 1'b0, '0, '0);
        run_txn(4'b1001, 0, 1'b0, '0, '0);

        // Randomized traffic.
        for (int t = 0; t < 40; t++) begin
            logic [N-1:0] v;
            v = N'($urandom_range(1, 15));
            if ($urandom_range(0, 4) == 0) begin
                req_valid = '0;
                @(posedge clk);
                #1;
            end
            run_txn(v, int'($urandom_range(0, 3)), 1'b0, '0, '0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
